anim_sequencer: RTL



---
 rtl/anim_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/anim_sequencer.sv
// rtl/anim_sequencer.sv - frame-synchronous animation phase, bob and scroll controller
// Ports:
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_frame_tick       one-cycle pulse per frame; the only event that moves animation state
//   i_pause            level; hold the animation at the next frame tick
//   i_step             pulse; request one advance while held
//   i_speed            effective period is PERIOD >> i_speed frames
//   o_phase            current sprite phase select
//   o_y_offset         sprite vertical bob offset (BOB on odd phases)
//   o_scroll_x         background scroll position, modulo SCROLL_WRAP
//   o_phase_strobe     one-cycle pulse on the cycle an advance becomes visible
//   o_paused           high while holding
module anim_sequencer #(
    parameter int PHASES      = 2,
    parameter int PERIOD      = 16,
    parameter int BOB         = 8,
    parameter int X_BITS      = 10,
    parameter int SCROLL_STEP = 8,
    parameter int SCROLL_WRAP = 800
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_frame_tick,
    input  logic                         i_pause,
    input  logic                         i_step,
    input  logic [1:0]                   i_speed,
    output logic [$clog2(PHASES)-1:0]    o_phase,
    output logic [$clog2(BOB+1)-1:0]     o_y_offset,
    output logic [X_BITS-1:0]            o_scroll_x,
    output logic                         o_phase_strobe,
    output logic                         o_paused
);

    localparam int PH_W  = $clog2(PHASES);
    localparam int Y_W   = $clog2(BOB + 1);
    localparam int CNT_W = $clog2(PERIOD);
    localparam int SUM_W = X_BITS + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_limit;
    logic               r_step_req;
    logic               w_step_req_next;
    logic               w_advance;

    logic [PH_W-1:0]    r_phase;
    logic [Y_W-1:0]     r_y_offset;
    logic [X_BITS-1:0]  r_scroll_x;
    logic               r_phase_strobe;

    logic [PH_W-1:0]    w_phase_inc;
    logic [SUM_W-1:0]   w_scroll_sum;
    logic [X_BITS-1:0]  w_scroll_next;

    // Last count value of the current period; a speed increase can leave the
    // counter above it, so the compare below uses >=.
    assign w_limit = CNT_W'((PERIOD >> i_speed) - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_frame_cnt <= '0;
            r_step_req  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_frame_cnt <= w_cnt_next;
            r_step_req  <= w_step_req_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_frame_cnt;
        w_step_req_next = r_step_req;
        w_advance       = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_step_req_next = 1'b0;
                if (i_frame_tick) begin
                    if (i_pause) begin
                        w_state_next = ST_HOLD;
                    end else if (r_frame_cnt >= w_limit) begin
                        w_advance  = 1'b1;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_frame_cnt + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (i_frame_tick) begin
                    if (!i_pause) begin
                        w_state_next    = ST_RUN;
                        w_step_req_next = 1'b0;
                    end else if (r_step_req || i_step) begin
                        // Any number of steps since the last tick collapse into one advance.
                        w_advance       = 1'b1;
                        w_cnt_next      = '0;
                        w_step_req_next = 1'b0;
                    end
                end else if (i_step) begin
                    w_step_req_next = 1'b1;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        o_paused = (r_state == ST_HOLD);
    end

    assign w_phase_inc   = (r_phase == PH_W'(PHASES - 1)) ? '0 : r_phase + PH_W'(1);
    // One extra bit so the sum cannot overflow before the wrap compare.
    assign w_scroll_sum  = {1'b0, r_scroll_x} + SUM_W'(SCROLL_STEP);
    assign w_scroll_next = (w_scroll_sum >= SUM_W'(SCROLL_WRAP))
                         ? X_BITS'(w_scroll_sum - SUM_W'(SCROLL_WRAP))
                         : w_scroll_sum[X_BITS-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase        <= '0;
            r_y_offset     <= '0;
            r_scroll_x     <= '0;
            r_phase_strobe <= 1'b0;
        end else begin
            r_phase_strobe <= w_advance;
            if (w_advance) begin
                r_phase    <= w_phase_inc;
                r_y_offset <= w_phase_inc[0] ? Y_W'(BOB) : '0;
                r_scroll_x <= w_scroll_next;
            end
        end
    end

    assign o_phase        = r_phase;
    assign o_y_offset     = r_y_offset;
    assign o_scroll_x     = r_scroll_x;
    assign o_phase_strobe = r_phase_strobe;

endmodule
